// File: rtl/distance_filter.sv
// distance_filter: periodic capture of an upstream inch count into a 4-entry
// window, 4-sample moving average, and a proximity flag with hysteresis.
//
// Ports
//   clk           system clock, all logic on the rising edge
//   reset         asynchronous, active-low reset
//   distance      unsigned inch count, sampled only on capture edges
//   avg_distance  window sum >> 2, updated one edge after a capture
//   avg_valid     one-cycle strobe, avg_distance updated this cycle
//   filled        high once 4 captures have landed since reset
//   near          set at avg <= ALARM_ON, cleared at avg >= ALARM_OFF
module distance_filter #(
  parameter int SAMPLE_CYCLES = 500_000,
  parameter int ALARM_ON      = 12,
  parameter int ALARM_OFF     = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] distance,
  output logic [7:0] avg_distance,
  output logic       avg_valid,
  output logic       filled,
  output logic       near
);

  localparam int            TW     = (SAMPLE_CYCLES > 1) ? $clog2(SAMPLE_CYCLES) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(SAMPLE_CYCLES - 1);
  localparam logic [7:0]    ON8    = 8'(ALARM_ON);
  localparam logic [7:0]    OFF8   = 8'(ALARM_OFF);

  if (ALARM_ON >= ALARM_OFF || SAMPLE_CYCLES < 2) begin : g_param_err
    $error("distance_filter: need ALARM_ON < ALARM_OFF and SAMPLE_CYCLES >= 2");
  end

  typedef enum logic {FILLING, RUN} state_t;

  state_t          state_q, state_d;
  logic [TW-1:0]   timer;
  logic [3:0][7:0] win_q;    // [0] newest, [3] oldest
  logic [2:0]      count;
  logic            capture;
  logic            cap_q;    // capture delayed one edge: the average update slot
  logic [9:0]      sum;
  logic [7:0]      avg_new;

  // Wrap edge of the timer is the capture edge; first one lands on the
  // SAMPLE_CYCLES-th edge after reset release because the timer starts at 0.
  assign capture = (timer == T_LAST);

  // 10 bits holds 4 * 255 without overflow.
  assign sum     = {2'b00, win_q[0]} + {2'b00, win_q[1]}
                 + {2'b00, win_q[2]} + {2'b00, win_q[3]};
  assign avg_new = sum[9:2];

  assign filled  = (state_q == RUN);

  always_comb begin
    state_d = state_q;
    case (state_q)
      FILLING: if (capture && count == 3'd3) state_d = RUN;
      RUN:     state_d = RUN;   // only reset leaves RUN
      default: state_d = FILLING;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= FILLING;
      timer   <= '0;
      win_q   <= '0;
      count   <= '0;
      cap_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cap_q   <= capture;
      timer   <= capture ? '0 : timer + 1'b1;
      if (capture) begin
        win_q <= {win_q[2:0], distance};
        if (count != 3'd4) count <= count + 3'd1;
      end
    end
  end

  // The window already holds the new sample on the edge after capture, so the
  // average, strobe and hysteresis flag all move together here. state_q is RUN
  // at this point exactly when the capture just taken was the 4th or later.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      avg_distance <= '0;
      avg_valid    <= 1'b0;
      near         <= 1'b0;
    end else begin
      avg_valid <= 1'b0;
      if (cap_q && state_q == RUN) begin
        avg_distance <= avg_new;
        avg_valid    <= 1'b1;
        if (avg_new <= ON8)       near <= 1'b1;
        else if (avg_new >= OFF8) near <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_distance_filter.sv
// Bench for distance_filter with SAMPLE_CYCLES=10. A queue-based reference
// model tracks the captured samples by edge number since reset release and
// predicts every output on every cycle; directed checks cover the called-out
// corner cases on top of that.
module tb_distance_filter;
  localparam int SC = 10;
  localparam int ON = 12;
  localparam int OFF = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] distance;
  logic [7:0] avg_distance;
  logic       avg_valid, filled, near;

  distance_filter #(.SAMPLE_CYCLES(SC), .ALARM_ON(ON), .ALARM_OFF(OFF)) dut (
    .clk(clk), .reset(reset), .distance(distance),
    .avg_distance(avg_distance), .avg_valid(avg_valid),
    .filled(filled), .near(near)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // reference model state
  int   edge_cnt;
  int   win[$];
  int   cnt;
  bit   pend;
  int   e_avg;
  bit   e_valid, e_near;
  int   first_valid_edge;

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d (edge %0d)", tag, obs, exp, edge_cnt);
    end
  endtask

  task automatic model_reset();
    edge_cnt = 0; win.delete(); cnt = 0; pend = 0;
    e_avg = 0; e_valid = 0; e_near = 0; first_valid_edge = -1;
  endtask

  task automatic model_edge(input int d);
    int s;
    edge_cnt++;
    e_valid = 0;
    if (pend && cnt == 4) begin
      s = 0;
      foreach (win[i]) s += win[i];
      e_avg   = s / 4;
      e_valid = 1;
      if (e_avg <= ON) e_near = 1;
      else if (e_avg >= OFF) e_near = 0;
    end
    pend = 0;
    if (edge_cnt % SC == 0) begin
      win.push_front(d);
      if (win.size() > 4) void'(win.pop_back());
      if (cnt < 4) cnt++;
      pend = 1;
    end
  endtask

  task automatic check_all();
    check("avg_distance", int'(avg_distance), e_avg);
    check("avg_valid",    int'(avg_valid),    int'(e_valid));
    check("filled",       int'(filled),       int'(cnt == 4));
    check("near",         int'(near),         int'(e_near));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    model_edge(int'(distance));
    if (e_valid && first_valid_edge < 0) first_valid_edge = edge_cnt;
    check_all();
  endtask

  // Run until one capture edge takes v; optionally scramble distance on every
  // edge that is not a capture edge.
  task automatic cap(input int v, input bit tog);
    do begin
      if ((edge_cnt + 1) % SC == 0) distance = 8'(v);
      else distance = tog ? 8'($urandom_range(0, 255)) : 8'(v);
      step();
    end while (edge_cnt % SC != 0);
  endtask

  task automatic cap_n(input int v, input int n, input bit tog);
    for (int i = 0; i < n; i++) cap(v, tog);
  endtask

  task automatic apply_reset(input int cycles);
    reset = 1'b0;
    #1;
    model_reset();
    check("rst_avg",   int'(avg_distance), 0);
    check("rst_valid", int'(avg_valid), 0);
    check("rst_filled", int'(filled), 0);
    check("rst_near",  int'(near), 0);
    for (int i = 0; i < cycles; i++) @(posedge clk);
    #1;
    check("rst_hold_avg", int'(avg_distance), 0);
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0;
    distance = 8'd0;
    model_reset();

    // reset state, then 20 held: first strobe one edge after the 40th edge
    apply_reset(3);
    cap_n(20, 4, 0);
    check("cap4_edge", edge_cnt, 40);
    step();
    check("first_valid_edge", first_valid_edge, 41);
    check("r026_avg", int'(avg_distance), 20);
    check("r026_near", int'(near), 0);

    // 10,11,12,13 -> 46>>2 = 11, inside the alarm band
    cap(10, 0); cap(11, 0); cap(12, 0); cap(13, 0);
    step();
    check("r027_avg", int'(avg_distance), 11);
    check("r027_near", int'(near), 1);

    // hysteresis walk
    cap_n(10, 4, 0); cap_n(14, 4, 0); step();
    check("hyst14_near", int'(near), 1);
    cap_n(15, 4, 0); step();
    check("hyst15_near", int'(near), 1);
    cap_n(16, 4, 0); step();
    check("hyst16_near", int'(near), 0);
    cap_n(13, 4, 0); step();
    check("hyst13_near", int'(near), 0);
    cap_n(12, 4, 0); step();
    check("hyst12_near", int'(near), 1);

    // full-scale, then one zero: 765>>2
    cap_n(255, 4, 0); step();
    check("max_avg", int'(avg_distance), 255);
    cap(0, 0); step();
    check("max_then0_avg", int'(avg_distance), 191);

    // random captures with distance toggling between captures
    for (int i = 0; i < 12; i++) cap(int'($urandom_range(0, 30)), 1);
    step();

    // mid-operation reset after 6 captures, then a fresh fill
    apply_reset(2);
    cap_n(7, 6, 1);
    step();
    @(negedge clk);
    apply_reset(3);
    for (int i = 0; i < 4; i++) cap(int'($urandom_range(0, 40)), 1);
    step();
    check("rerun_first_valid", first_valid_edge, 41);
    step(); step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
